// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: FIFO read port plus valid/ready output stream of the read controller.
interface fifo_rd_ctrl_if #(parameter int DATA_WIDTH = 32);
   logic                  rd_en;
   logic                  empty;
   logic                  rd_ack;
   logic                  rd_err;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   modport master (output rd_en, out_valid, out_data,
                   input  empty, rd_ack, rd_err, fifo_dout, out_ready);
   modport slave  (input  rd_en, out_valid, out_data,
                   output empty, rd_ack, rd_err, fifo_dout, out_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: drains a programmed burst from the FIFO read port onto a valid/ready stream.
module fifo_rd_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [3:0]           burst_len,
   input  logic                 err_clr,
   fifo_rd_ctrl_if.master       bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [3:0]           words_read
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE, ERR} state_t;
   localparam logic [7:0] TO = 8'(TIMEOUT);
   state_t                state;
   logic [3:0]            remaining;
   logic [7:0]            cnt;
   logic [DATA_WIDTH-1:0] data_q;
   assign bus.rd_en     = state == ISSUE && !bus.empty;
   assign bus.out_valid = state == HOLD;
   assign bus.out_data  = data_q;
   assign busy          = state != IDLE && state != ERR;
   assign done          = state == DONE;
   assign err           = state == ERR;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         remaining  <= '0;
         cnt        <= '0;
         data_q     <= '0;
         err_code   <= '0;
         words_read <= '0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  words_read <= '0;
                  cnt        <= '0;
                  remaining  <= burst_len > 4'd8 ? 4'd8 : burst_len;
                  state      <= burst_len == 4'd0 ? DONE : ISSUE;
               end
            ISSUE:
               if (!bus.empty) state <= WAIT;
               else begin
                  cnt <= cnt + 8'd1;
                  if (cnt + 8'd1 >= TO) begin
                     state    <= ERR;
                     err_code <= 2'd3;
                  end
               end
            WAIT:
               if (bus.rd_err) begin
                  state    <= ERR;
                  err_code <= 2'd1;
               end else if (bus.rd_ack) begin
                  data_q     <= bus.fifo_dout;
                  remaining  <= remaining - 4'd1;
                  words_read <= words_read + 4'd1;
                  cnt        <= '0;
                  state      <= HOLD;
               end else begin
                  state    <= ERR;
                  err_code <= 2'd2;
               end
            HOLD:
               if (bus.out_ready) state <= remaining == 4'd0 ? DONE : ISSUE;
            DONE:
               state <= IDLE;
            ERR:
               if (err_clr) begin
                  state    <= IDLE;
                  err_code <= '0;
               end
            default:
               state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the 8-deep FIFO. On a start pulse it drains a programmed number of words from the FIFO's read port (rd_en / d_out / rd_ack / rd_err). Each word goes out on a valid/ready stream to the downstream consumer. It sits between the FIFO's read interface and the consumer logic, and it is the only agent that drives the FIFO's rd_en.

## Interface
- DATA_WIDTH, 32, width of FIFO data and output stream
- TIMEOUT, 16, consecutive empty cycles tolerated in ISSUE before error (1..255)
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a burst; ignored unless state is IDLE
- burst_len  in  4  words to read, sampled with start; 0..8 legal, 9..15 clamped to 8
- err_clr  in  1  leaves ERR state
- empty  in  1  FIFO empty flag
- rd_ack  in  1  FIFO read acknowledge, valid one cycle after accepted rd_en
- rd_err  in  1  FIFO read error (underflow), same timing as rd_ack
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid with rd_ack
- rd_en  out  1  FIFO read enable
- out_valid  out  1  stream data valid
- out_data  out  DATA_WIDTH  stream data
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  state is not IDLE and not ERR
- done  out  1  one-cycle pulse, burst completed
- err  out  1  high while in ERR
- err_code  out  2  0 none, 1 rd_err, 2 no ack, 3 timeout; held until err_clr
- words_read  out  4  words delivered in current/last burst

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DONE, ERR (3-bit encoding, registered).
- IDLE:
  - start with burst_len≠0: latch remaining = min(burst_len, 8), clear words_read and timeout counter, go to ISSUE.
  - start with burst_len=0: go to DONE; no FIFO access.
- ISSUE:
  - rd_en = 1 when empty=0 (combinational from state and empty); go to WAIT.
  - When empty=1: rd_en = 0, timeout counter increments.
  - Counter reaching TIMEOUT: go to ERR, err_code=3.
- WAIT, first matching rule applies:
  - rd_err=1: go to ERR, err_code=1.
  - Else rd_ack=1: register fifo_dout into out_data, remaining−1, words_read+1, clear timeout counter, go to HOLD.
  - Else: go to ERR, err_code=2.
- HOLD: out_valid=1 and out_data stable until out_ready=1. On the accept cycle:
  - remaining=0: go to DONE.
  - Otherwise: go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: out_valid=0, rd_en=0. err_clr=1 returns to IDLE and clears err_code. start is ignored in ERR.
- At most one read is outstanding; rd_en is never asserted in any state other than ISSUE.
- words_read holds its final value in IDLE until the next accepted start.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - rd_en=0, out_valid=0, out_data=0, done=0, err=0, err_code=0, words_read=0, busy=0.
  - remaining=0, timeout counter=0.
- start sampled at edge E0: ISSUE during cycle 1; rd_en high in cycle 1 if not empty.
- FIFO returns rd_ack/fifo_dout in cycle 2 (WAIT). out_valid rises in cycle 3.
- Best case with out_ready held high: 3 cycles per word; an N-word burst has done high in cycle 3N+1 after start.
- out_ready low: HOLD extends indefinitely; no timeout applies in HOLD.
- Reset mid-burst: everything returns to reset values. The pending FIFO rd_ack after reset is ignored (state IDLE).
- start while busy: no effect, no latch of burst_len.
- err_clr and start in the same cycle in ERR: go to IDLE only; start is not honoured.

## Test plan
- Reset, then start with burst_len=3. FIFO holds 0xA1, 0xB2, 0xC3 and out_ready=1 -> rd_en pulses in cycles 1, 4, 7; out_data 0xA1/0xB2/0xC3 in cycles 3, 6, 9; done in cycle 10; words_read=3.
- Back-pressure: burst_len=2, out_ready=0 for 5 cycles after the first out_valid -> out_data stable, no second rd_en until the accept; done follows the second accept.
- Empty stall and timeout (TIMEOUT=16): empty=1 after start -> rd_en stays 0; after 16 cycles err=1, err_code=3, busy=0. err_clr -> IDLE, err_code=0.
- FIFO errors: rd_err=1 in WAIT -> err_code=1. Separately, neither rd_ack nor rd_err in WAIT -> err_code=2. In both cases out_valid stays 0.
- Edge lengths: burst_len=0 -> done one cycle after start, rd_en never high. burst_len=12 -> exactly 8 words read.
- Assert reset_n=0 while in HOLD -> out_valid and rd_en drop immediately. After release, a new burst_len=1 completes normally.
